// File: rtl/bus_pkg.sv
// Shared types and constants for the 68000 bus-cycle controller.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: n/a.
package bus_pkg;

  // Controller states: idle bus, cycle in progress, acknowledged, bus-errored.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_BERR = 2'd3
  } state_t;

  // Target of a decoded /AS cycle.
  typedef enum logic [1:0] {
    REG_ROM   = 2'd0,
    REG_RAM   = 2'd1,
    REG_DUART = 2'd2,
    REG_NONE  = 2'd3
  } region_t;

  // A23..A20 region codes.
  localparam logic [3:0] ADDR_ROM     = 4'h0;
  localparam logic [3:0] ADDR_RAM     = 4'h1;
  localparam logic [3:0] ADDR_ROM_ALT = 4'hE;
  localparam logic [3:0] ADDR_DUART   = 4'hF;

  // Counter widths: wait states up to 15, watchdog up to 255, boot count up to 255.
  localparam int WAIT_CNT_W = 4;
  localparam int WDOG_CNT_W = 8;
  localparam int BOOT_CNT_W = 8;

  // Map A23..A20 to a region. With the boot overlay present, region 0 reads
  // as ROM only while boot_active, and 4'hE is a permanent ROM alias.
  function automatic region_t decode_region(input logic [3:0] addr,
                                            input logic       overlay_en,
                                            input logic       boot_active);
    region_t r;
    r = REG_NONE;
    case (addr)
      ADDR_ROM:     r = (overlay_en && !boot_active) ? REG_RAM : REG_ROM;
      ADDR_RAM:     r = REG_RAM;
      ADDR_DUART:   r = REG_DUART;
      ADDR_ROM_ALT: r = overlay_en ? REG_ROM : REG_NONE;
      default:      r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-cycle watchdog: saturating clock counter that flags when a cycle has waited BERR_TIMEOUT clocks.
// Latency: expired is combinational and high during the clock whose edge brings the count to BERR_TIMEOUT.
// Backpressure: none; clear has priority over enable.
module bus_watchdog
  import bus_pkg::*;
#(
  parameter int BERR_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_CNT_W-1:0] LIMIT      = WDOG_CNT_W'(BERR_TIMEOUT);
  localparam logic [WDOG_CNT_W-1:0] LIMIT_LAST = WDOG_CNT_W'(BERR_TIMEOUT - 1);

  logic [WDOG_CNT_W-1:0] cnt;

  // Count enabled clocks since the last clear, stopping at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + WDOG_CNT_W'(1);
    end
  end

  // The controller acts on the same edge that the count reaches the limit,
  // so flag one count early.
  always_comb begin
    expired = enable && !clear && (cnt >= LIMIT_LAST);
  end

endmodule

// File: rtl/bus_cycle_ctl.sv
// 68000 bus-cycle controller: decodes /AS cycles, drives ROM/RAM/DUART selects, /DTACK and /BERR.
// Latency: selects one edge after /AS is sampled; /DTACK after per-region wait states or the DUART ack.
// Backpressure: cycles with no acknowledge get /BERR after BERR_TIMEOUT clocks; optional BOOT_OVERLAY_EN macro.
module bus_cycle_ctl
  import bus_pkg::*;
#(
  parameter int ROM_WAIT     = 2,
  parameter int RAM_WAIT     = 0,
  parameter int BERR_TIMEOUT = 64
`ifdef BOOT_OVERLAY_EN
  , parameter int BOOT_CYCLES = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       as_n,
  input  logic       uds_n,
  input  logic       lds_n,
  input  logic [3:0] addr,
  input  logic       duart_dtack_n,
  output logic       rom_evn_cs_n,
  output logic       rom_odd_cs_n,
  output logic       ram_evn_cs_n,
  output logic       ram_odd_cs_n,
  output logic       duart_cs_n,
  output logic       dtack_n,
  output logic       berr_n
);

  state_t                state;
  region_t               region;
  region_t               dec_region;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] dec_wait;
  logic                  duart_ack_q;
  logic                  ack_now;
  logic                  wdog_clear;
  logic                  wdog_en;
  logic                  wdog_expired;
  logic                  overlay_en;
  logic                  boot_active;
  logic                  rom_evn_nxt;
  logic                  rom_odd_nxt;
  logic                  ram_evn_nxt;
  logic                  ram_odd_nxt;
  logic                  duart_nxt;

`ifdef BOOT_OVERLAY_EN
  logic [BOOT_CNT_W-1:0] boot_cnt;
  assign overlay_en  = 1'b1;
  assign boot_active = (boot_cnt < BOOT_CNT_W'(BOOT_CYCLES));
`else
  assign overlay_en  = 1'b0;
  assign boot_active = 1'b0;
`endif

  // Decode the address of a new cycle and pick its wait-state count.
  always_comb begin
    dec_region = decode_region(addr, overlay_en, boot_active);
    dec_wait   = '0;
    case (dec_region)
      REG_ROM: dec_wait = WAIT_CNT_W'(ROM_WAIT);
      REG_RAM: dec_wait = WAIT_CNT_W'(RAM_WAIT);
      default: dec_wait = '0;
    endcase
  end

  // Chip-select levels for the latched region; memory byte lanes follow the
  // live data strobes, the DUART ignores them.
  always_comb begin
    rom_evn_nxt = 1'b1;
    rom_odd_nxt = 1'b1;
    ram_evn_nxt = 1'b1;
    ram_odd_nxt = 1'b1;
    duart_nxt   = 1'b1;
    case (region)
      REG_ROM: begin
        rom_evn_nxt = uds_n;
        rom_odd_nxt = lds_n;
      end
      REG_RAM: begin
        ram_evn_nxt = uds_n;
        ram_odd_nxt = lds_n;
      end
      REG_DUART: duart_nxt = 1'b0;
      default: ;
    endcase
  end

  // Acknowledge source for the current cycle: wait-state countdown for
  // memory, the registered DUART acknowledge for the DUART, never otherwise.
  always_comb begin
    ack_now = 1'b0;
    case (region)
      REG_ROM, REG_RAM: ack_now = (wait_cnt == '0);
      REG_DUART:        ack_now = duart_ack_q;
      default:          ack_now = 1'b0;
    endcase
  end

  // Register the DUART acknowledge, only while its cycle is live, so a stale
  // strobe from a previous access cannot complete a new one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duart_ack_q <= 1'b0;
    end else begin
      duart_ack_q <= (state == ST_WAIT) && (region == REG_DUART) && !as_n && !duart_dtack_n;
    end
  end

  assign wdog_clear = (state == ST_IDLE);
  assign wdog_en    = (state == ST_WAIT) && !as_n;

  bus_watchdog #(
    .BERR_TIMEOUT (BERR_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wdog_clear),
    .enable  (wdog_en),
    .expired (wdog_expired)
  );

  // Bus-cycle FSM with registered chip selects, /DTACK and /BERR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      region       <= REG_NONE;
      wait_cnt     <= '0;
      rom_evn_cs_n <= 1'b1;
      rom_odd_cs_n <= 1'b1;
      ram_evn_cs_n <= 1'b1;
      ram_odd_cs_n <= 1'b1;
      duart_cs_n   <= 1'b1;
      dtack_n      <= 1'b1;
      berr_n       <= 1'b1;
`ifdef BOOT_OVERLAY_EN
      boot_cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!as_n) begin
            region   <= dec_region;
            wait_cnt <= dec_wait;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (as_n) begin
            // CPU abandoned the cycle: drop everything without a pulse.
            rom_evn_cs_n <= 1'b1;
            rom_odd_cs_n <= 1'b1;
            ram_evn_cs_n <= 1'b1;
            ram_odd_cs_n <= 1'b1;
            duart_cs_n   <= 1'b1;
            state        <= ST_IDLE;
          end else if (ack_now) begin
            // Acknowledge beats a coincident watchdog expiry.
            rom_evn_cs_n <= rom_evn_nxt;
            rom_odd_cs_n <= rom_odd_nxt;
            ram_evn_cs_n <= ram_evn_nxt;
            ram_odd_cs_n <= ram_odd_nxt;
            duart_cs_n   <= duart_nxt;
            dtack_n      <= 1'b0;
            state        <= ST_ACK;
          end else if (wdog_expired) begin
            rom_evn_cs_n <= 1'b1;
            rom_odd_cs_n <= 1'b1;
            ram_evn_cs_n <= 1'b1;
            ram_odd_cs_n <= 1'b1;
            duart_cs_n   <= 1'b1;
            berr_n       <= 1'b0;
            state        <= ST_BERR;
          end else begin
            rom_evn_cs_n <= rom_evn_nxt;
            rom_odd_cs_n <= rom_odd_nxt;
            ram_evn_cs_n <= ram_evn_nxt;
            ram_odd_cs_n <= ram_odd_nxt;
            duart_cs_n   <= duart_nxt;
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
            end
          end
        end
        ST_ACK, ST_BERR: begin
          if (as_n) begin
            rom_evn_cs_n <= 1'b1;
            rom_odd_cs_n <= 1'b1;
            ram_evn_cs_n <= 1'b1;
            ram_odd_cs_n <= 1'b1;
            duart_cs_n   <= 1'b1;
            dtack_n      <= 1'b1;
            berr_n       <= 1'b1;
            state        <= ST_IDLE;
`ifdef BOOT_OVERLAY_EN
            // Completed cycles (ack or bus error) advance the boot window.
            if (boot_active) begin
              boot_cnt <= boot_cnt + BOOT_CNT_W'(1);
            end
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctl.sv
// Testbench for bus_cycle_ctl: table of bus cycles plus hand sequences for abort and reset.
// Latency: expected ack/berr latency and chip selects pushed to a scoreboard at /AS sample.
// Backpressure: every wait is bounded; expired bounds are reported as failures.
module tb_bus_cycle_ctl;

  logic       clk;
  logic       rst_n;
  logic       as_n;
  logic       uds_n;
  logic       lds_n;
  logic [3:0] addr;
  logic       duart_dtack_n;
  logic       rom_evn_cs_n;
  logic       rom_odd_cs_n;
  logic       ram_evn_cs_n;
  logic       ram_odd_cs_n;
  logic       duart_cs_n;
  logic       dtack_n;
  logic       berr_n;

  bus_cycle_ctl dut (
    .clk           (clk),
    .reset         (rst_n),
    .as_n          (as_n),
    .uds_n         (uds_n),
    .lds_n         (lds_n),
    .addr          (addr),
    .duart_dtack_n (duart_dtack_n),
    .rom_evn_cs_n  (rom_evn_cs_n),
    .rom_odd_cs_n  (rom_odd_cs_n),
    .ram_evn_cs_n  (ram_evn_cs_n),
    .ram_odd_cs_n  (ram_odd_cs_n),
    .duart_cs_n    (duart_cs_n),
    .dtack_n       (dtack_n),
    .berr_n        (berr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle request: inputs, optional DUART ack edge (relative to /AS sample),
  // expected selects one edge later, and expected terminating event.
  typedef struct {
    logic [3:0] addr;
    logic       uds_n;
    logic       lds_n;
    int         dd;
    logic [4:0] cs_exp;
    bit         berr_exp;
    int         lat_exp;
  } vec_t;

  typedef struct {
    bit         berr;
    int         lat;
    logic [4:0] cs;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   mon_en = 0;
  logic prev_d = 1'b1;
  logic prev_b = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] cs_vec();
    return {rom_evn_cs_n, rom_odd_cs_n, ram_evn_cs_n, ram_odd_cs_n, duart_cs_n};
  endfunction

  function automatic logic [6:0] all_out();
    return {cs_vec(), dtack_n, berr_n};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every falling /DTACK or /BERR pops one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!dtack_n || !berr_n) chk("dtack_berr_exclusive", 32'({dtack_n, berr_n} == 2'b00), 32'(0));
      if ((!dtack_n && prev_d) || (!berr_n && prev_b)) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 32'({dtack_n, berr_n}), 32'(2'b11));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("event_kind", 32'({dtack_n, berr_n}), e.berr ? 32'(2'b10) : 32'(2'b01));
          chk("event_latency", 32'(cyc - start_cyc), 32'(e.lat));
          chk("event_cs", 32'(cs_vec()), 32'(e.cs));
        end
      end
    end
    prev_d = dtack_n;
    prev_b = berr_n;
  end

  task automatic do_cycle(input vec_t v);
    exp_t e;
    bit   done;
    @(negedge clk);
    addr  = v.addr;
    uds_n = v.uds_n;
    lds_n = v.lds_n;
    as_n  = 1'b0;
    @(negedge clk);
    start_cyc = cyc;
    e.berr = v.berr_exp;
    e.lat  = v.lat_exp;
    e.cs   = v.berr_exp ? 5'b11111 : v.cs_exp;
    sb.push_back(e);
    done = 1'b0;
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      if (k == 1) chk("cs_first_edge", 32'(cs_vec()), 32'(v.cs_exp));
      if (!dtack_n || !berr_n) done = 1'b1;
      else if (v.dd != 0 && k == v.dd - 1) duart_dtack_n = 1'b0;
    end
    if (!done) begin
      errors++;
      $display("FAIL cycle_timeout addr=%0h actual=no_event expected=event", v.addr);
      sb.delete();
    end
    @(negedge clk);
    chk("hold_until_as_release", 32'({dtack_n, berr_n}), v.berr_exp ? 32'(2'b10) : 32'(2'b01));
    as_n = 1'b1;
    duart_dtack_n = 1'b1;
    @(negedge clk);
    chk("release_all_high", 32'(all_out()), 32'(7'h7F));
  endtask

  initial begin
    vec_t v;
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; addr = 4'h0; duart_dtack_n = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(all_out()), 32'(7'h7F));
    rst_n = 1'b1;
    mon_en = 1'b1;

    //          addr  uds   lds   dd  cs_exp    berr  lat
    vecs[0]  = '{4'h1, 1'b0, 1'b0, 0,  5'b11001, 1'b0, 1};
    vecs[1]  = '{4'h0, 1'b0, 1'b1, 0,  5'b01111, 1'b0, 3};
    vecs[2]  = '{4'h0, 1'b1, 1'b0, 0,  5'b10111, 1'b0, 3};
    vecs[3]  = '{4'h0, 1'b0, 1'b0, 0,  5'b00111, 1'b0, 3};
    vecs[4]  = '{4'h1, 1'b1, 1'b0, 0,  5'b11101, 1'b0, 1};
    vecs[5]  = '{4'hF, 1'b1, 1'b1, 5,  5'b11110, 1'b0, 6};
    vecs[6]  = '{4'h7, 1'b0, 1'b0, 0,  5'b11111, 1'b1, 64};
    vecs[7]  = '{4'hF, 1'b0, 1'b0, 63, 5'b11110, 1'b0, 64};
    vecs[8]  = '{4'hF, 1'b0, 1'b0, 64, 5'b11110, 1'b1, 64};
    vecs[9]  = '{4'h3, 1'b1, 1'b1, 0,  5'b11111, 1'b1, 64};
`ifdef BOOT_OVERLAY_EN
    vecs[10] = '{4'hE, 1'b0, 1'b0, 0,  5'b00111, 1'b0, 3};
`else
    vecs[10] = '{4'hE, 1'b0, 1'b0, 0,  5'b11111, 1'b1, 64};
`endif
    vecs[11] = '{4'h1, 1'b0, 1'b1, 0,  5'b11011, 1'b0, 1};

    foreach (vecs[i]) do_cycle(vecs[i]);

    // Aborted ROM cycle: /AS released before the wait states elapse.
    @(negedge clk);
    addr = 4'h0; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_cs_asserted", 32'(cs_vec()), 32'(5'b00111));
    as_n = 1'b1;
    @(negedge clk);
    chk("abort_all_high", 32'(all_out()), 32'(7'h7F));
    repeat (4) @(negedge clk);
    chk("abort_no_pulse", 32'({dtack_n, berr_n}), 32'(2'b11));

    // Reset pulsed mid-WAIT of a ROM cycle.
    @(negedge clk);
    addr = 4'h0; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_cs", 32'(cs_vec()), 32'(5'b00111));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'(all_out()), 32'(7'h7F));
    as_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{4'h0, 1'b0, 1'b0, 0, 5'b00111, 1'b0, 3};
    do_cycle(v);

`ifdef BOOT_OVERLAY_EN
    // Boot overlay: four completed cycles with region 0 as ROM, then RAM; 4'hE stays ROM.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{4'hE, 1'b0, 1'b0, 0, 5'b00111, 1'b0, 3};
    do_cycle(v);
    for (int i = 0; i < 3; i++) begin
      v = '{4'h0, 1'b0, 1'b0, 0, 5'b00111, 1'b0, 3};
      do_cycle(v);
    end
    v = '{4'h0, 1'b0, 1'b0, 0, 5'b11001, 1'b0, 1};
    do_cycle(v);
    v = '{4'hE, 1'b0, 1'b0, 0, 5'b00111, 1'b0, 3};
    do_cycle(v);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
